// File: rtl/ex_if.sv
// ex_if: operand/result bundle between ID/EX, the execute stage and EX/MEM
// Signals:
//   aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i : from ID/EX into ex
//   wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o   : from ex toward EX/MEM and hazard control
// Modports: master is the pipeline side, slave is the ex stage.
interface ex_if #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
);
    logic [7:0]         aluop_i;
    logic [2:0]         alusel_i;
    logic [WIDTH-1:0]   reg1_i;
    logic [WIDTH-1:0]   reg2_i;
    logic [RADDR_W-1:0] wd_i;
    logic               wreg_i;
    logic               flush_i;
    logic [RADDR_W-1:0] wd_o;
    logic               wreg_o;
    logic [WIDTH-1:0]   wdata_o;
    logic               whilo_o;
    logic [WIDTH-1:0]   hi_o;
    logic [WIDTH-1:0]   lo_o;
    logic               stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex.sv
// ex: execute stage -- combinational logic/shift/arith ALU plus optional iterative DIV/DIVU
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous reset, active HIGH despite the name; forces every output to 0
//   bus   : ex_if.slave -- operands/op codes in, result, HI/LO write and stall request out
// Build option: define EX_DIV_EN to build the WIDTH-cycle restoring divider with its
// stall request; otherwise DIV/DIVU finish at once with HI/LO write of zeros and no stall.
module ex #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    ex_if.slave  bus
);
    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0]        a, b, logic_res, shift_res, arith_res, alu_res, hi, lo;
    logic signed [WIDTH-1:0] sra_res;
    logic [SW-1:0]           sa;
    logic [7:0]              op;
    logic                    is_div, whilo, stall, slt, sltu;

    assign a      = bus.reg1_i;
    assign b      = bus.reg2_i;
    assign op     = bus.aluop_i;
    assign sa     = a[SW-1:0];
    assign is_div = op == OP_DIV || op == OP_DIVU;
    // kept separate so the surrounding unsigned ternary cannot turn >>> into a logical shift
    assign sra_res = $signed(b) >>> sa;
    assign slt     = $signed(a) < $signed(b);
    assign sltu    = a < b;

    always_comb begin
        logic_res = op == OP_OR  ? a | b :
                    op == OP_AND ? a & b :
                    op == OP_XOR ? a ^ b :
                    op == OP_NOR ? ~(a | b) : '0;
        shift_res = op == OP_SLL ? b << sa :
                    op == OP_SRL ? b >> sa :
                    op == OP_SRA ? sra_res : '0;
        arith_res = op == OP_ADDU ? a + b :
                    op == OP_SUBU ? a - b :
                    op == OP_SLT  ? {{(WIDTH-1){1'b0}}, slt} :
                    op == OP_SLTU ? {{(WIDTH-1){1'b0}}, sltu} : '0;
        alu_res   = bus.alusel_i == SEL_LOGIC ? logic_res :
                    bus.alusel_i == SEL_SHIFT ? shift_res :
                    bus.alusel_i == SEL_ARITH ? arith_res : '0;
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

    state_t           state;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] dvs, rem, quo;
    logic [WIDTH:0]   shifted, diff;
    logic             neg_q, neg_r, sgn;

    assign sgn = op == OP_DIV;
    // quo starts as the dividend magnitude and shifts out into rem while quotient bits shift in
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (bus.flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (is_div) begin
                    if (b == '0) begin
                        state <= ZERO;
                    end else begin
                        quo   <= sgn && a[WIDTH-1] ? -a : a;
                        dvs   <= sgn && b[WIDTH-1] ? -b : b;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= sgn && a[WIDTH-1];
                        state <= BUSY;
                    end
                end
                ZERO: begin
                    quo   <= '1;
                    rem   <= a;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    state <= DONE;
                end
                BUSY: begin
                    // a borrow out of the trial subtraction means restore the shifted remainder
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + SW'(1);
                    if (cnt == SW'(WIDTH - 1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = !bus.flush_i && (state == IDLE ? is_div : state == ZERO || state == BUSY);
    assign whilo = is_div && !bus.flush_i && state == DONE;
    assign lo    = whilo ? (neg_q ? -quo : quo) : '0;
    assign hi    = whilo ? (neg_r ? -rem : rem) : '0;
`else
    logic unused_ok;

    assign unused_ok = clk ^ bus.flush_i;
    assign stall     = 1'b0;
    assign whilo     = is_div;
    assign lo        = '0;
    assign hi        = '0;
`endif

    assign bus.wd_o       = rst_n ? '0 : bus.wd_i;
    assign bus.wreg_o     = !rst_n && bus.wreg_i;
    assign bus.wdata_o    = rst_n || is_div ? '0 : alu_res;
    assign bus.whilo_o    = !rst_n && whilo;
    assign bus.hi_o       = rst_n ? '0 : hi;
    assign bus.lo_o       = rst_n ? '0 : lo;
    assign bus.stallreq_o = !rst_n && stall;
endmodule

// File: tb/tb_ex.sv
// tb_ex: table-driven ALU vectors plus scoreboarded divide, flush and reset sequences for ex
module tb_ex;
    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] wdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vt[18];

    always #5 clk = ~clk;

    ex_if #(.WIDTH(32), .RADDR_W(5)) bus ();
    ex #(.WIDTH(32), .RADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: output with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, " wdata"}, bus.wdata_o, e.wdata);
            check({name, " hi"}, bus.hi_o, e.hi);
            check({name, " lo"}, bus.lo_o, e.lo);
            check({name, " whilo"}, 32'(bus.whilo_o), 32'(e.whilo));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " wd"}, 32'(bus.wd_o), 0);
        check({name, " wreg"}, 32'(bus.wreg_o), 0);
        check({name, " wdata"}, bus.wdata_o, 0);
        check({name, " whilo"}, 32'(bus.whilo_o), 0);
        check({name, " hi"}, bus.hi_o, 0);
        check({name, " lo"}, bus.lo_o, 0);
        check({name, " stall"}, 32'(bus.stallreq_o), 0);
    endtask

    task automatic issue_div(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] hi, input logic [31:0] lo);
        @(posedge clk);
        #1;
        drive(op, SEL_NOP, r1, r2, 5'd9, 1'b0);
        sb.push_back('{wdata: 32'h0, hi: hi, lo: lo, whilo: 1'b1});
    endtask

    // counts stalled cycles from the current cycle until the HI/LO strobe appears
    task automatic wait_done(input string name, input int exp_stalls);
        int  stalls = 0;
        bit  done = 0;
        exp_t dummy;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.whilo_o) begin
                done = 1;
                check_out(name);
                check({name, " stall at done"}, 32'(bus.stallreq_o), 0);
            end else if (bus.stallreq_o) begin
                stalls++;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: no whilo_o within 100 cycles", name);
            if (sb.size() != 0) dummy = sb.pop_front();
        end
        check({name, " stall cycles"}, stalls, exp_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{OP_OR,   SEL_LOGIC, 32'h0000FF00, 32'h00F0F0F0, 32'h00F0FFF0};
        vt[1]  = '{OP_AND,  SEL_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vt[2]  = '{OP_XOR,  SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
        vt[3]  = '{OP_NOR,  SEL_LOGIC, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00};
        vt[4]  = '{OP_SLL,  SEL_SHIFT, 32'h00000008, 32'h12345678, 32'h34567800};
        vt[5]  = '{OP_SRL,  SEL_SHIFT, 32'h00000004, 32'h80000000, 32'h08000000};
        vt[6]  = '{OP_SRA,  SEL_SHIFT, 32'h00000004, 32'h80000000, 32'hF8000000};
        vt[7]  = '{OP_SRA,  SEL_SHIFT, 32'h00000024, 32'h7000000F, 32'h07000000};
        vt[8]  = '{OP_SRL,  SEL_SHIFT, 32'h0000001F, 32'hFFFFFFFF, 32'h00000001};
        vt[9]  = '{OP_ADDU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        vt[10] = '{OP_SUBU, SEL_ARITH, 32'h00000001, 32'h00000002, 32'hFFFFFFFF};
        vt[11] = '{OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vt[12] = '{OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[13] = '{OP_SLT,  SEL_ARITH, 32'h00000005, 32'h00000003, 32'h00000000};
        vt[14] = '{OP_SLTU, SEL_ARITH, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        vt[15] = '{OP_OR,   SEL_NOP,   32'h00001234, 32'h00005678, 32'h00000000};
        vt[16] = '{OP_ADDU, 3'b111,    32'h00000003, 32'h00000004, 32'h00000000};
        vt[17] = '{OP_SLT,  SEL_ARITH, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};

        bus.flush_i = 1'b0;
        drive(OP_OR, SEL_LOGIC, 32'h0000FF00, 32'h00F0F0F0, 5'd7, 1'b1);
        #2;
        check_all_zero("reset alu");
        drive(OP_DIV, SEL_NOP, 32'd100, 32'd7, 5'd7, 1'b1);
        #1;
        check_all_zero("reset div");
        @(posedge clk);
        #2;
        rst_n = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i].op, vt[i].sel, vt[i].r1, vt[i].r2, 5'(i + 3), i[0]);
            sb.push_back('{wdata: vt[i].wdata, hi: 32'h0, lo: 32'h0, whilo: 1'b0});
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
            check($sformatf("vec%0d wd", i), 32'(bus.wd_o), 32'(i + 3));
            check($sformatf("vec%0d wreg", i), 32'(bus.wreg_o), 32'(i[0]));
            check($sformatf("vec%0d stall", i), 32'(bus.stallreq_o), 0);
        end

`ifdef EX_DIV_EN
        issue_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done("div -7/2", 33);

        issue_div(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
        wait_done("divu ffffffff/16", 33);
        @(posedge clk);
        #1;
        drive(OP_ADDU, SEL_ARITH, 32'd3, 32'd4, 5'd2, 1'b1);
        sb.push_back('{wdata: 32'd7, hi: 32'h0, lo: 32'h0, whilo: 1'b0});
        @(negedge clk);
        check_out("addu after divu");
        check("addu after divu stall", 32'(bus.stallreq_o), 0);

        issue_div(OP_DIV, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        wait_done("div by zero", 2);

        issue_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        wait_done("div min/-1", 33);
        @(posedge clk);
        #1;
        sb.push_back('{wdata: 32'h0, hi: 32'h0, lo: 32'h80000000, whilo: 1'b1});
        wait_done("div back-to-back", 33);

        issue_div(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        wait_done("div 7/-2", 33);

        for (int k = 0; k < 3; k++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom_range(1, 32'hFFFF);
            issue_div(OP_DIVU, x, y, x % y, x / y);
            wait_done($sformatf("divu rand%0d", k), 33);
        end

        issue_div(OP_DIV, 32'd1000, 32'd7, 32'd6, 32'd142);
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush stall", 32'(bus.stallreq_o), 0);
        check("flush whilo", 32'(bus.whilo_o), 0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        wait_done("div after flush", 33);

        issue_div(OP_DIV, 32'hFFFFFF00, 32'h10, 32'h0, 32'hFFFFFFF0);
        bus.wreg_i = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check_all_zero("async reset");
        repeat (2) begin
            @(negedge clk);
            check_all_zero("held reset");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wait_done("div after reset", 33);
`else
        @(posedge clk);
        #1;
        drive(OP_DIV, SEL_NOP, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b0);
        sb.push_back('{wdata: 32'h0, hi: 32'h0, lo: 32'h0, whilo: 1'b1});
        @(negedge clk);
        check_out("div no divider");
        check("div no divider stall", 32'(bus.stallreq_o), 0);
        @(posedge clk);
        #1;
        drive(OP_DIVU, SEL_ARITH, 32'hFFFFFFFF, 32'h10, 5'd9, 1'b1);
        sb.push_back('{wdata: 32'h0, hi: 32'h0, lo: 32'h0, whilo: 1'b1});
        @(negedge clk);
        check_out("divu no divider");
        check("divu no divider stall", 32'(bus.stallreq_o), 0);
`endif

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage integer pipeline, fed directly by the ID/EX pipeline register and driving the EX/MEM register. It evaluates logic, shift and arithmetic operations combinationally. It runs DIV/DIVU on an iterative 32-cycle restoring divider, and stalls the upstream pipeline through `stallreq_o` while the divider is busy. Results and HI/LO write requests are presented combinationally to EX/MEM.

## Interface
- `WIDTH`, 32: datapath width. The divider iteration count equals `WIDTH`.
- `RADDR_W`, 5: destination register address width.

- `clk`, in, 1: pipeline clock.
- `rst_n`, in, 1: reset. Asynchronous and active-high: asserted when 1, despite the name.
- `aluop_i`, in, `AluOpBus`: operation code from ID/EX.
- `alusel_i`, in, `AluSelBus`: result-class select from ID/EX.
- `reg1_i`, in, `WIDTH`: operand 1. For shifts this is the shift amount; for division it is the dividend.
- `reg2_i`, in, `WIDTH`: operand 2. For shifts this is the value shifted; for division it is the divisor.
- `wd_i`, in, `RADDR_W`: destination register.
- `wreg_i`, in, 1: register write enable.
- `flush_i`, in, 1: cancels an in-flight division.
- `wd_o`, out, `RADDR_W`: equals `wd_i`.
- `wreg_o`, out, 1: equals `wreg_i`.
- `wdata_o`, out, `WIDTH`: general-register result.
- `whilo_o`, out, 1: HI/LO write strobe.
- `hi_o`, out, `WIDTH`: HI write data.
- `lo_o`, out, `WIDTH`: LO write data.
- `stallreq_o`, out, 1: request to freeze PC, IF/ID and ID/EX.

## Operation
- Logic class (`EXE_RES_LOGIC`):
  - OR, AND, XOR, NOR of `reg1_i`/`reg2_i`.
- Shift class (`EXE_RES_SHIFT`):
  - SLL, SRL, SRA of `reg2_i` by `reg1_i[4:0]`.
  - SRA is arithmetic and fills with `reg2_i[31]`.
- Arithmetic class (`EXE_RES_ARITH`):
  - ADDU, SUBU: modulo 2^32, no overflow trap.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0.
- `EXE_RES_NOP` or an unknown `alusel_i`: `wdata_o` = 0.
- DIV and DIVU:
  - `wdata_o` = 0. `lo_o` = quotient, `hi_o` = remainder, `whilo_o` = 1 only in DONE.
  - DIV works on operand magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
- All other ops: `whilo_o` = 0, `hi_o` = `lo_o` = 0.
- Divider FSM states: IDLE, ZERO, BUSY, DONE.
  - IDLE:
    - On DIV/DIVU with `flush_i` = 0 and divisor ≠ 0: latch the magnitudes and the signed flag, clear the counter, go to BUSY.
    - On DIV/DIVU with `flush_i` = 0 and divisor = 0: go to ZERO.
  - ZERO: load quotient = all ones and remainder = `reg1_i`, go to DONE.
  - BUSY: one restoring shift-subtract step per cycle. After step `WIDTH` (counter = `WIDTH`−1), go to DONE.
  - DONE: present the sign-corrected result and return to IDLE unconditionally.
- `stallreq_o` = 1 in these cases:
  - in IDLE while a DIV/DIVU is present and `flush_i` = 0;
  - in ZERO;
  - in BUSY.
- `stallreq_o` = 0 in DONE and in every other case.
- `flush_i` = 1 in any state forces IDLE on the next edge, with `whilo_o` = 0 and `stallreq_o` = 0 in that cycle.
- While `rst_n` = 1, every output is forced to 0 and the FSM is held in IDLE with all internal registers at 0.

## Timing
- Non-divide ops: zero latency, combinational from the inputs.
- DIV/DIVU with a nonzero divisor:
  - issue cycle C: IDLE, stall;
  - C+1 through C+32: BUSY, stall;
  - C+33: DONE, `whilo_o` = 1 and stall = 0, so ID/EX advances at the end of C+33.
  - Total: 34 cycles in EX.
- Divide by zero: C in IDLE, C+1 in ZERO, C+2 in DONE. Total: 3 cycles.
- The operands must stay stable through DONE. ID/EX guarantees this because it is held by the stall.
- A DIV that immediately follows a DIV starts in the IDLE cycle after the first one's DONE.
- Asynchronous reset mid-BUSY abandons the division with no HI/LO write. The first cycle after release is IDLE.

## Configuration
- `EX_DIV_EN` defined: the divider FSM is present as described above.
- `EX_DIV_EN` undefined:
  - No divider logic is built and `stallreq_o` is tied to 0.
  - DIV/DIVU complete in one cycle with `whilo_o` = 1 and `hi_o` = `lo_o` = 0.

## Test plan
- Basic ALU:
  - OR with reg1 = 0x0000FF00, reg2 = 0x00F0F0F0 → `wdata_o` = 0x00F0FFF0.
  - SRA with reg1 = 4, reg2 = 0x80000000 → `wdata_o` = 0xF8000000.
  - SLT with reg1 = 0xFFFFFFFF, reg2 = 1 → `wdata_o` = 1; SLTU with the same operands → 0.
- Signed DIV: reg1 = −7 (0xFFFFFFF9), reg2 = 2:
  - `stallreq_o` stays high for exactly 33 cycles;
  - then DONE gives `lo_o` = 0xFFFFFFFD and `hi_o` = 0xFFFFFFFF with `whilo_o` = 1.
- DIVU: reg1 = 0xFFFFFFFF, reg2 = 0x10 → `lo_o` = 0x0FFFFFFF, `hi_o` = 0xF, 34 cycles in total.
- Divide by zero: DIV with reg1 = 100, reg2 = 0 → `lo_o` = 0xFFFFFFFF, `hi_o` = 100, DONE in the third cycle.
- Flush and reset:
  - assert `flush_i` at BUSY step 10 → next cycle IDLE, `stallreq_o` = 0, no `whilo_o` pulse;
  - repeat with `rst_n` pulsed → all outputs 0 during reset, IDLE after release.
- Back-to-back DIVU then ADDU: the ADDU result is correct in the cycle after DONE, with no extra stall.
